// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse sequencer.
// Runs the reset/enable handshake with the mouse, then assembles 3-byte
// stream packets and presents them to the bus side with an interrupt pulse.
// Optional response watchdog: define MOUSE_MASTER_WATCHDOG_EN.
module mouse_master_sm #(
  parameter int POWERUP_CYCLES = 5_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       STREAMING,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    PWRUP       = 4'd0,
    TX_RST      = 4'd1,
    WT_RST_SENT = 4'd2,
    RX_ACK1     = 4'd3,
    RX_SELFTEST = 4'd4,
    RX_ID       = 4'd5,
    TX_EN       = 4'd6,
    WT_EN_SENT  = 4'd7,
    RX_ACK2     = 4'd8,
    RX_B0       = 4'd9,
    RX_B1       = 4'd10,
    RX_B2       = 4'd11,
    PKT_OUT     = 4'd12
  } state_t;

  localparam logic [25:0] PWR_LAST     = 26'(POWERUP_CYCLES - 1);
  localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);
`ifdef MOUSE_MASTER_WATCHDOG_EN
  localparam logic WATCHDOG_ON = 1'b1;
`else
  localparam logic WATCHDOG_ON = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [25:0] cnt_reg, cnt_next;
  logic [7:0]  shadow0_reg, shadow1_reg, shadow2_reg;
  logic [7:0]  status_reg, dx_reg, dy_reg;
  logic        int_reg, stream_reg;
  logic        cap0, cap1, cap2, set_stream;
  logic        wd_expired, rx_clean;

  // Watchdog only fires when enabled; the counter is cleared on every state change.
  assign wd_expired = WATCHDOG_ON & (cnt_reg == TIMEOUT_LAST);
  assign rx_clean   = BYTE_READY & (BYTE_ERROR_CODE == 2'b00);

  // Next-state logic and byte-capture strobes.
  always_comb begin
    state_next = state_reg;
    cap0       = 1'b0;
    cap1       = 1'b0;
    cap2       = 1'b0;
    set_stream = 1'b0;
    case (state_reg)
      PWRUP:       if (cnt_reg == PWR_LAST) state_next = TX_RST;
      TX_RST:      state_next = WT_RST_SENT;
      WT_RST_SENT: if (BYTE_SENT) state_next = RX_ACK1;
                   else if (wd_expired) state_next = TX_RST;
      RX_ACK1:     if (BYTE_READY)
                     state_next = (rx_clean && BYTE_READ == 8'hFA) ? RX_SELFTEST : TX_RST;
                   else if (wd_expired) state_next = TX_RST;
      RX_SELFTEST: if (BYTE_READY)
                     state_next = (rx_clean && BYTE_READ == 8'hAA) ? RX_ID : TX_RST;
                   else if (wd_expired) state_next = TX_RST;
      RX_ID:       if (BYTE_READY)
                     state_next = (rx_clean && BYTE_READ == 8'h00) ? TX_EN : TX_RST;
                   else if (wd_expired) state_next = TX_RST;
      TX_EN:       state_next = WT_EN_SENT;
      WT_EN_SENT:  if (BYTE_SENT) state_next = RX_ACK2;
                   else if (wd_expired) state_next = TX_RST;
      RX_ACK2:     if (BYTE_READY) begin
                     if (rx_clean && BYTE_READ == 8'hFA) begin
                       state_next = RX_B0;
                       set_stream = 1'b1;
                     end else begin
                       state_next = TX_RST;
                     end
                   end else if (wd_expired) state_next = TX_RST;
      // Bit 3 of the status byte is always 1; use it to resync the packet.
      RX_B0:       if (rx_clean && BYTE_READ[3]) begin
                     state_next = RX_B1;
                     cap0       = 1'b1;
                   end
      RX_B1:       if (BYTE_READY) begin
                     if (rx_clean) begin
                       state_next = RX_B2;
                       cap1       = 1'b1;
                     end else begin
                       state_next = RX_B0;
                     end
                   end
      RX_B2:       if (BYTE_READY) begin
                     if (rx_clean) begin
                       state_next = PKT_OUT;
                       cap2       = 1'b1;
                     end else begin
                       state_next = RX_B0;
                     end
                   end
      PKT_OUT:     state_next = RX_B0;
      default:     state_next = PWRUP;
    endcase
  end

  // Saturating cycle counter, restarted whenever the state changes.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) cnt_next = '0;
    else if (cnt_reg != '1)      cnt_next = cnt_reg + 26'd1;
  end

  // State, counter, packet shadow and bus-side output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= PWRUP;
      cnt_reg     <= '0;
      shadow0_reg <= '0;
      shadow1_reg <= '0;
      shadow2_reg <= '0;
      status_reg  <= '0;
      dx_reg      <= '0;
      dy_reg      <= '0;
      int_reg     <= 1'b0;
      stream_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (cap0) shadow0_reg <= BYTE_READ;
      if (cap1) shadow1_reg <= BYTE_READ;
      if (cap2) shadow2_reg <= BYTE_READ;
      if (set_stream) stream_reg <= 1'b1;
      // All three packet bytes become visible together with the interrupt.
      int_reg <= (state_reg == PKT_OUT);
      if (state_reg == PKT_OUT) begin
        status_reg <= shadow0_reg;
        dx_reg     <= shadow1_reg;
        dy_reg     <= shadow2_reg;
      end
    end
  end

  // Transmit request/byte and receiver enable decoded from the state.
  always_comb begin
    SEND_BYTE    = (state_reg == TX_RST) || (state_reg == TX_EN);
    BYTE_TO_SEND = 8'h00;
    if (state_reg == TX_RST || state_reg == WT_RST_SENT) BYTE_TO_SEND = 8'hFF;
    if (state_reg == TX_EN  || state_reg == WT_EN_SENT)  BYTE_TO_SEND = 8'hF4;
    READ_ENABLE  = (state_reg == RX_ACK1) || (state_reg == RX_SELFTEST) ||
                   (state_reg == RX_ID)   || (state_reg == RX_ACK2)     ||
                   (state_reg == RX_B0)   || (state_reg == RX_B1)       ||
                   (state_reg == RX_B2);
  end

  assign MOUSE_STATUS   = status_reg;
  assign MOUSE_DX       = dx_reg;
  assign MOUSE_DY       = dy_reg;
  assign SEND_INTERRUPT = int_reg;
  assign STREAMING      = stream_reg;
  assign MASTER_STATE   = state_reg;

endmodule

// File: tb/tb_mouse_master_sm.sv
// tb_mouse_master_sm: directed, table-driven bench for mouse_master_sm
// (POWERUP_CYCLES=100, TIMEOUT_CYCLES=1000).
module tb_mouse_master_sm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT, STREAMING;
  logic [3:0] MASTER_STATE;

  mouse_master_sm #(.POWERUP_CYCLES(100), .TIMEOUT_CYCLES(1000)) dut (
    .CLK(CLK), .RESET(RESET),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT), .STREAMING(STREAMING),
    .MASTER_STATE(MASTER_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    logic [3:0] exp_state;
  } vec_t;

  vec_t init_tab[3];
  vec_t strm_tab[6];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Advance one clock; return at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic [1:0] e);
    BYTE_READ = d;
    BYTE_ERROR_CODE = e;
    BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic tx_done();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  // Count cycles until SEND_BYTE is seen, bounded by max.
  task automatic wait_send(input int max, output int n, output logic found);
    n = 0;
    found = 1'b0;
    while (n < max && !found) begin
      tick();
      n++;
      if (SEND_BYTE) found = 1'b1;
    end
  endtask

  initial begin
    int   n;
    logic found;

    init_tab[0] = '{8'hFA, 2'b00, 4'd4};
    init_tab[1] = '{8'hAA, 2'b00, 4'd5};
    init_tab[2] = '{8'h00, 2'b00, 4'd6};
    // Discard cases: bad sync bit, error on byte 1, error on byte 2.
    strm_tab[0] = '{8'h01, 2'b00, 4'd9};
    strm_tab[1] = '{8'h08, 2'b00, 4'd10};
    strm_tab[2] = '{8'h10, 2'b01, 4'd9};
    strm_tab[3] = '{8'h18, 2'b00, 4'd10};
    strm_tab[4] = '{8'h22, 2'b00, 4'd11};
    strm_tab[5] = '{8'h33, 2'b10, 4'd9};

    // Reset state
    @(negedge CLK);
    check("rst_state", 32'(MASTER_STATE), 32'd0);
    check("rst_outputs", {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS,
                          MOUSE_DX, SEND_INTERRUPT, STREAMING}, 32'd0);
    RESET = 1'b1;

    // Power-up wait then 0xFF command
    wait_send(200, n, found);
    check("pwrup_found", 32'(found), 32'd1);
    check("pwrup_cycles", 32'(n), 32'd100);
    check("tx_rst_byte", 32'(BYTE_TO_SEND), 32'hFF);
    check("tx_rst_rden", 32'(READ_ENABLE), 32'd0);
    tick();
    check("wt_rst_state", 32'(MASTER_STATE), 32'd2);
    check("wt_rst_pulse", 32'(SEND_BYTE), 32'd0);
    check("wt_rst_hold", 32'(BYTE_TO_SEND), 32'hFF);
    check("wt_rst_rden", 32'(READ_ENABLE), 32'd0);
    rx_byte(8'hFA, 2'b00);
    check("wt_ignore_ready", 32'(MASTER_STATE), 32'd2);
    // Simultaneous BYTE_SENT and BYTE_READY: only BYTE_SENT matters here.
    BYTE_SENT = 1'b1;
    rx_byte(8'hFA, 2'b00);
    BYTE_SENT = 1'b0;
    check("sent_and_ready", 32'(MASTER_STATE), 32'd3);
    check("rx_ack1_rden", 32'(READ_ENABLE), 32'd1);

    // Handshake replies from table
    for (int i = 0; i < 3; i++) begin
      rx_byte(init_tab[i].data, init_tab[i].err);
      check($sformatf("init_row%0d_state", i), 32'(MASTER_STATE), 32'(init_tab[i].exp_state));
    end
    check("tx_en_pulse", 32'(SEND_BYTE), 32'd1);
    check("tx_en_byte", 32'(BYTE_TO_SEND), 32'hF4);
    tick();
    check("wt_en_state", 32'(MASTER_STATE), 32'd7);
    tx_done();
    check("rx_ack2_state", 32'(MASTER_STATE), 32'd8);
    check("pre_stream", 32'(STREAMING), 32'd0);
    rx_byte(8'hFA, 2'b00);
    check("stream_state", 32'(MASTER_STATE), 32'd9);
    check("streaming", 32'(STREAMING), 32'd1);

    // Good packet, interrupt two cycles after the last byte
    rx_byte(8'h09, 2'b00);
    rx_byte(8'h05, 2'b00);
    rx_byte(8'hFB, 2'b00);
    check("pkt1_no_int_yet", 32'(SEND_INTERRUPT), 32'd0);
    check("pkt1_old_status", 32'(MOUSE_STATUS), 32'h00);
    tick();
    check("pkt1_int", 32'(SEND_INTERRUPT), 32'd1);
    check("pkt1_data", {8'h00, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0009_05FB);
    check("pkt1_state", 32'(MASTER_STATE), 32'd9);
    tick();
    check("pkt1_int_single", 32'(SEND_INTERRUPT), 32'd0);

    // Discard cases from table: no interrupt, outputs unchanged
    for (int i = 0; i < 6; i++) begin
      rx_byte(strm_tab[i].data, strm_tab[i].err);
      check($sformatf("strm_row%0d_state", i), 32'(MASTER_STATE), 32'(strm_tab[i].exp_state));
      tick();
      check($sformatf("strm_row%0d_out", i),
            {7'd0, SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0009_05FB);
    end

    // Second good packet
    rx_byte(8'h28, 2'b00);
    rx_byte(8'h80, 2'b00);
    rx_byte(8'h7F, 2'b00);
    tick();
    check("pkt2", {7'd0, SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0128_807F);

    // Asynchronous reset mid-stream
    #2 RESET = 1'b0;
    #1;
    check("async_rst", {23'd0, STREAMING, SEND_INTERRUPT, MOUSE_STATUS[2:0], MASTER_STATE}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    wait_send(200, n, found);
    check("pwrup2_cycles", 32'(n), 32'd100);
    tick();
    tx_done();
    rx_byte(8'hFA, 2'b00);
    rx_byte(8'hFE, 2'b00);
    check("bad_reply_restart", {23'd0, SEND_BYTE, BYTE_TO_SEND}, 32'h1FF);
    check("bad_reply_stream", 32'(STREAMING), 32'd0);
    tick();
    tx_done();
    rx_byte(8'hFA, 2'b11);
    check("err_reply_restart", {23'd0, SEND_BYTE, BYTE_TO_SEND}, 32'h1FF);
    tick();
    tx_done();
    check("no_reply_state", 32'(MASTER_STATE), 32'd3);

    // No reply after 0xFF: watchdog restart or indefinite wait
    wait_send(1100, n, found);
`ifdef MOUSE_MASTER_WATCHDOG_EN
    check("wd_found", 32'(found), 32'd1);
    check("wd_cycles", 32'(n), 32'd1000);
    check("wd_byte", 32'(BYTE_TO_SEND), 32'hFF);
`else
    check("nowd_found", 32'(found), 32'd0);
    check("nowd_state", 32'(MASTER_STATE), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
